dual_port_access_arbiter: RTL and testbench
===========================================

DUAL_PORT_ACCESS_ARBITER -- requirements
Module: dual_port_access_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles allowed before abort (TIMEOUT >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, [1:0]: per-requester transaction request, held high until that requester's gnt bit pulses.
REQ-007 The block SHALL have port req_we, input, [1:0]: per-requester direction, 1 = write, 0 = read.
REQ-008 The block SHALL have ports req_addr0 and req_addr1, input, [ADDR_W-1:0]: per-requester address.
REQ-009 The block SHALL have ports req_wdata0 and req_wdata1, input, [DATA_W-1:0]: per-requester write data.
REQ-010 The block SHALL have port gnt, output, [1:0]: one-cycle completion pulse to the served requester.
REQ-011 The block SHALL have port rdata, output, [DATA_W-1:0]: read data, valid while gnt pulses.
REQ-012 The block SHALL have port err, output, 1 bit: timeout flag, valid while gnt pulses.
REQ-013 The block SHALL have ports mem_addr [ADDR_W-1:0], mem_wdata [DATA_W-1:0], mem_wen [1] and mem_ren [1], all outputs: the shared memory port.
REQ-014 The block SHALL have ports mem_ready [1] and mem_rdata [DATA_W-1:0], inputs: memory completion strobe and read data.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-017 In IDLE with req != 0, the block SHALL select a winner, latch its we/addr/wdata into mem_*, assert mem_wen (we=1) or mem_ren (we=0), and enter BUSY on the next edge.
REQ-018 Arbitration SHALL be round-robin: when both req bits are high, the requester not served last wins; with a single request, that requester wins.
REQ-019 In BUSY, mem_addr, mem_wdata, mem_wen and mem_ren SHALL stay stable, and exactly one of mem_wen/mem_ren SHALL be high.
REQ-020 On an edge in BUSY with mem_ready=1, the block SHALL drop mem_wen/mem_ren, capture mem_rdata into rdata (reads only; rdata holds otherwise), set gnt[winner]=1 and err=0, update last-served, and enter RESP.
REQ-021 In RESP, gnt SHALL be high for exactly one cycle; the block SHALL return to IDLE without issuing a new request in that cycle.
REQ-022 Minimum latency SHALL be req sampled in cycle N, mem enable high in cycle N+1, gnt in cycle N+2 (when mem_ready=1 in N+1); throughput SHALL be one transaction per 3 cycles.
REQ-023 mem_ready while not in BUSY SHALL be ignored.
REQ-024 Dropping a req bit before its gnt SHALL be a protocol violation; the block SHALL complete the latched transaction regardless.
REQ-025 A requester that keeps req high after gnt SHALL be treated as a new request in IDLE.

Reset
REQ-026 While reset=1, the block SHALL go asynchronously to IDLE with gnt=0, err=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, rdata=0, the timeout counter at 0 and last-served=1 (requester 0 wins first).
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction without issuing gnt.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY; if mem_ready stays low for TIMEOUT cycles, the block SHALL drop the mem enables, pulse gnt[winner] with err=1, leave rdata unchanged, update last-served, and enter RESP.
REQ-029 With ARB_TIMEOUT_EN defined, mem_ready arriving in the same cycle as expiry SHALL take priority (err=0).
REQ-030 Without ARB_TIMEOUT_EN, the counter SHALL be absent, err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Verification
REQ-031 The bench SHALL cover: req=01, we=0, addr0=0x100, mem_ready=1 in the first BUSY cycle, mem_rdata=0xA5 -> mem_ren high for 1 cycle at addr 0x100, then gnt=01 and rdata=0xA5 two cycles after the request.
REQ-032 The bench SHALL cover: req=11 held continuously after reset -> grant order 01, 10, 01, 10.
REQ-033 The bench SHALL cover: req=10, we=1, wdata1=0xDEAD, mem_ready delayed 5 cycles -> mem_wen and mem_wdata=0xDEAD stable for 5 cycles, then gnt=10.
REQ-034 The bench SHALL cover: ARB_TIMEOUT_EN defined, TIMEOUT=4, mem_ready held 0 -> mem_ren drops after 4 BUSY cycles, gnt pulses with err=1, and the next request proceeds normally.
REQ-035 The bench SHALL cover: reset asserted during BUSY -> outputs 0 immediately and no gnt; after release, req=11 -> requester 0 served first.

Source files
------------

// File: rtl/dual_port_access_arbiter.sv
// Purpose : two-requester round-robin arbiter in front of one shared memory port.
// Latency : req sampled in cycle N -> mem enable in N+1 -> gnt in N+2 at best; one transaction every 3 cycles.
// Backpressure: BUSY holds mem_* stable until mem_ready; requesters hold req until their gnt pulse.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req[1:0], req_we[1:0]         per-requester request and direction (1 = write)
//   req_addr0/1, req_wdata0/1     per-requester address and write data
//   gnt[1:0], rdata, err          completion pulse, read data and timeout flag (valid with gnt)
//   mem_addr, mem_wdata,
//   mem_wen, mem_ren              shared memory request, held for the whole access
//   mem_ready, mem_rdata          memory completion strobe and read data
//
// Optional feature: define ARB_TIMEOUT_EN to abort an access after TIMEOUT
// BUSY cycles without mem_ready (gnt pulses with err=1). Without it err is 0
// and BUSY waits for mem_ready indefinitely.

module dual_port_access_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("dual_port_access_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   r_winner;   // requester owning the access in flight
    logic   r_last;     // requester served most recently

    // Winner selection for the IDLE cycle: on contention the requester not
    // served last wins, otherwise whichever single requester is asking.
    logic              w_pick;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    always_comb begin
        w_pick = req[1];
        if (req == 2'b11) begin
            w_pick = ~r_last;
        end
        w_we    = w_pick ? req_we[1]  : req_we[0];
        w_addr  = w_pick ? req_addr1  : req_addr0;
        w_wdata = w_pick ? req_wdata1 : req_wdata0;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Counts completed BUSY cycles; reaching CNT_LAST means the current BUSY
    // cycle is the TIMEOUT-th one, so without mem_ready the access is aborted.
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_winner  <= 1'b0;
            r_last    <= 1'b1;
            gnt       <= 2'b00;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_winner  <= w_pick;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        mem_wen   <= w_we;
                        mem_ren   <= ~w_we;
                        r_state   <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end

                S_BUSY: begin
                    // mem_ready is checked first so a completion landing on
                    // the expiry cycle still counts as a clean access.
                    if (mem_ready) begin
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        if (mem_ren) begin
                            rdata <= mem_rdata;
                        end
                        gnt     <= r_winner ? 2'b10 : 2'b01;
                        r_last  <= r_winner;
                        r_state <= S_RESP;
`ifdef ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        // Abort: rdata deliberately keeps its previous value.
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        gnt     <= r_winner ? 2'b10 : 2'b01;
                        r_err   <= 1'b1;
                        r_last  <= r_winner;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
`endif
                    end
                end

                S_RESP: begin
                    // Single-cycle gnt; req is not looked at here, so a held
                    // request is picked up again from IDLE.
                    gnt     <= 2'b00;
`ifdef ARB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end

                default: begin
                    gnt     <= 2'b00;
                    mem_wen <= 1'b0;
                    mem_ren <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_access_arbiter.sv
// Purpose : randomized self-checking bench for dual_port_access_arbiter with a transaction-level model.
// Latency : checks the IDLE -> BUSY -> RESP timing of every access cycle by cycle.
// Backpressure: the bench plays the memory and inserts mem_ready delays.

module tb_dual_port_access_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic [1:0]    gnt;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen, mem_ren;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    dual_port_access_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_wdata0(req_wdata0),
        .req_wdata1(req_wdata1),
        .gnt       (gnt),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: who was served last and what rdata should show.
    int            m_last;
    logic [DW-1:0] m_rdata;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int b);
        req[b]    = 1'b1;
        req_we[b] = 1'($urandom_range(0, 1));
        if (b == 1) begin
            req_addr1  = $urandom;
            req_wdata1 = $urandom;
        end else begin
            req_addr0  = $urandom;
            req_wdata0 = $urandom;
        end
    endtask

    // One access from the IDLE cycle (req already driven) through the RESP
    // cycle; ends in the following IDLE cycle. d = BUSY cycles before
    // mem_ready rises.
    task automatic run_txn(input int d, input bit keep, output int w);
        logic          we_w;
        logic [AW-1:0] a_w;
        logic [DW-1:0] wd_w, rd_new;
        bit            expire;
        int            nb;

        w      = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        we_w   = req_we[w];
        a_w    = (w == 1) ? req_addr1  : req_addr0;
        wd_w   = (w == 1) ? req_wdata1 : req_wdata0;
        expire = TO_EN && (d >= TO);
        nb     = expire ? TO : d + 1;

        // mem_ready outside BUSY is noise the block must ignore.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        tick();
        check_eq("busy_wen",  64'(mem_wen),   64'(we_w));
        check_eq("busy_ren",  64'(mem_ren),   64'(!we_w));
        check_eq("busy_addr", 64'(mem_addr),  64'(a_w));
        check_eq("busy_wdat", 64'(mem_wdata), 64'(wd_w));
        check_eq("busy_gnt",  64'(gnt),       64'(0));

        for (int i = 0; i < nb; i++) begin
            mem_ready = (i == d);
            mem_rdata = $urandom;
            rd_new    = mem_rdata;
            tick();
            if (i < nb - 1) begin
                check_eq("hold_wen",  64'(mem_wen),   64'(we_w));
                check_eq("hold_ren",  64'(mem_ren),   64'(!we_w));
                check_eq("hold_addr", 64'(mem_addr),  64'(a_w));
                check_eq("hold_wdat", 64'(mem_wdata), 64'(wd_w));
                check_eq("hold_gnt",  64'(gnt),       64'(0));
            end else begin
                if (!expire && !we_w) m_rdata = rd_new;
                check_eq("gnt",      64'(gnt),     (w == 1) ? 64'h2 : 64'h1);
                check_eq("gnt_err",  64'(err),     64'(expire));
                check_eq("gnt_rdat", 64'(rdata),   64'(m_rdata));
                check_eq("done_wen", 64'(mem_wen), 64'(0));
                check_eq("done_ren", 64'(mem_ren), 64'(0));
                m_last = w;
            end
        end

        if (!keep) req[w] = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        tick();
        check_eq("resp_gnt",  64'(gnt),     64'(0));
        check_eq("resp_err",  64'(err),     64'(0));
        check_eq("resp_wen",  64'(mem_wen), 64'(0));
        check_eq("resp_ren",  64'(mem_ren), 64'(0));
        check_eq("resp_rdat", 64'(rdata),   64'(m_rdata));
        mem_ready = 1'b0;
    endtask

    initial begin
        int w;
        int d;

        reset      = 1'b1;
        req        = 2'b00;
        req_we     = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        m_last     = 1;
        m_rdata    = '0;

        tick();
        tick();
        check_eq("rst_gnt",   64'(gnt),       64'(0));
        check_eq("rst_err",   64'(err),       64'(0));
        check_eq("rst_wen",   64'(mem_wen),   64'(0));
        check_eq("rst_ren",   64'(mem_ren),   64'(0));
        check_eq("rst_addr",  64'(mem_addr),  64'(0));
        check_eq("rst_wdata", 64'(mem_wdata), 64'(0));
        check_eq("rst_rdata", 64'(rdata),     64'(0));
        reset = 1'b0;
        tick();

        // Both requesting continuously: grants alternate 01, 10, 01, 10.
        raise(0);
        raise(1);
        for (int i = 0; i < 4; i++) begin
            run_txn(0, (i < 3), w);
        end
        run_txn(1, 1'b0, w);   // drain requester 0
        check_eq("drained", 64'(req), 64'(0));

        // Single read: addr 0x100, immediate ready, data 0xA5.
        req        = 2'b01;
        req_we[0]  = 1'b0;
        req_addr0  = 32'h100;
        req_wdata0 = 32'h0;
        begin
            // Directed rdata value, so drive the memory by hand for this one.
            mem_ready = 1'b0;
            tick();
            check_eq("rd_ren",  64'(mem_ren),  64'(1));
            check_eq("rd_addr", 64'(mem_addr), 64'h100);
            req       = 2'b00;
            mem_ready = 1'b1;
            mem_rdata = 32'hA5;
            tick();
            check_eq("rd_gnt",   64'(gnt),     64'h1);
            check_eq("rd_rdata", 64'(rdata),   64'hA5);
            check_eq("rd_ren0",  64'(mem_ren), 64'(0));
            mem_ready = 1'b0;
            tick();
            check_eq("rd_gnt0",  64'(gnt),     64'(0));
            m_last  = 0;
            m_rdata = 32'hA5;
        end

        // Write from requester 1 with a delayed mem_ready.
        req        = 2'b10;
        req_we[1]  = 1'b1;
        req_addr1  = 32'h2000;
        req_wdata1 = 32'hDEAD;
        run_txn(TO_EN ? TO - 1 : 5, 1'b0, w);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort with err, then a normal access.
        req        = 2'b01;
        req_we[0]  = 1'b0;
        req_addr0  = 32'h300;
        run_txn(20, 1'b0, w);
        raise(0);
        run_txn(0, 1'b0, w);
`endif

        // Reset in the middle of BUSY abandons the access.
        req        = 2'b01;
        req_we[0]  = 1'b0;
        req_addr0  = 32'h440;
        tick();
        check_eq("pre_rst_ren", 64'(mem_ren), 64'(1));
        #1 reset = 1'b1;
        #1;
        check_eq("arst_gnt",  64'(gnt),       64'(0));
        check_eq("arst_ren",  64'(mem_ren),   64'(0));
        check_eq("arst_wen",  64'(mem_wen),   64'(0));
        check_eq("arst_addr", 64'(mem_addr),  64'(0));
        check_eq("arst_rdat", 64'(rdata),     64'(0));
        tick();
        check_eq("arst_gnt2", 64'(gnt),       64'(0));
        reset   = 1'b0;
        m_last  = 1;
        m_rdata = '0;
        raise(0);
        raise(1);
        run_txn(0, 1'b0, w);   // requester 0 must be first after reset

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if (req == 2'b00 && $urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    tick();
                    check_eq("idle_gnt", 64'(gnt),               64'(0));
                    check_eq("idle_en",  64'({mem_wen, mem_ren}), 64'(0));
                end
                mem_ready = 1'b0;
            end
            for (int b = 0; b < 2; b++) begin
                if (!req[b] && $urandom_range(0, 1) == 1) raise(b);
            end
            if (req == 2'b00) raise(int'($urandom_range(0, 1)));
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            run_txn(d, 1'($urandom_range(0, 1)), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
